// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall, bubble and flush sequencing for the five-stage pipeline
// Optional stall-cycle statistics counter is built only when PIPE_STALL_STATS_EN is defined.
module pipeline_stall_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_hazard,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PC_LE,
    output logic        IFID_LE,
    output logic        IDEX_LE,
    output logic        EXMEM_LE,
    output logic        control_select,
    output logic        IFID_flush,
    output logic        MEMWB_bubble,
    output logic        mem_timeout,
    output logic [1:0]  ctrl_state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RST_HOLD   = 2'd0,
        RUN        = 2'd1,
        LOAD_STALL = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    localparam logic [3:0] LD_RELOAD   = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(MEM_TIMEOUT - 1);
    localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);

    state_e     state_q, state_d;
    state_e     ret_state_q, ret_state_d;
    logic [3:0] ld_cnt_q, ld_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;
    logic       mem_stall;

    assign mem_stall = mem_req && !mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_HOLD;
            ret_state_q   <= RUN;
            ld_cnt_q      <= 4'd0;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            ld_cnt_q      <= ld_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ret_state_d    = ret_state_q;
        ld_cnt_d       = ld_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        PC_LE          = 1'b1;
        IFID_LE        = 1'b1;
        IDEX_LE        = 1'b1;
        EXMEM_LE       = 1'b1;
        control_select = 1'b0;
        IFID_flush     = 1'b0;
        MEMWB_bubble   = 1'b0;

        unique case (state_q)
            RST_HOLD: begin
                PC_LE          = 1'b0;
                IFID_LE        = 1'b0;
                IDEX_LE        = 1'b0;
                EXMEM_LE       = 1'b0;
                control_select = 1'b1;
                IFID_flush     = 1'b1;
                MEMWB_bubble   = 1'b1;
                state_d        = RUN;
            end

            RUN, LOAD_STALL: begin
                if (mem_stall) begin
                    // Freeze the whole pipe; ld_cnt is held so a load stall resumes where it left off.
                    PC_LE        = 1'b0;
                    IFID_LE      = 1'b0;
                    IDEX_LE      = 1'b0;
                    EXMEM_LE     = 1'b0;
                    MEMWB_bubble = 1'b1;
                    ret_state_d  = state_q;
                    wait_cnt_d   = 8'd1;
                    state_d      = MEM_WAIT;
                end else if (state_q == RUN) begin
                    if (load_hazard) begin
                        PC_LE          = 1'b0;
                        IFID_LE        = 1'b0;
                        control_select = 1'b1;
                        if (MULTI_STALL) begin
                            ld_cnt_d = LD_RELOAD;
                            state_d  = LOAD_STALL;
                        end
                    end else if (branch_taken) begin
                        IFID_flush = 1'b1;
                    end
                end else begin
                    PC_LE          = 1'b0;
                    IFID_LE        = 1'b0;
                    control_select = 1'b1;
                    ld_cnt_d       = ld_cnt_q - 4'd1;
                    if (ld_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ret_state_q;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Watchdog expiry: force a release and latch the sticky flag.
                    mem_timeout_d = 1'b1;
                    state_d       = ret_state_q;
                end else begin
                    PC_LE        = 1'b0;
                    IFID_LE      = 1'b0;
                    IDEX_LE      = 1'b0;
                    EXMEM_LE     = 1'b0;
                    MEMWB_bubble = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = RST_HOLD;
            end
        endcase
    end

    assign mem_timeout = mem_timeout_q;
    assign ctrl_state  = state_q;

`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((state_q != RST_HOLD) && !PC_LE && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
// Vectors are {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, control_select, IFID_flush, MEMWB_bubble}.
module tb_pipeline_stall_controller;

    localparam logic [6:0] V_RESET  = 7'b0000_111;
    localparam logic [6:0] V_RUN    = 7'b1111_000;
    localparam logic [6:0] V_STALL  = 7'b0011_100;
    localparam logic [6:0] V_FLUSH  = 7'b1111_010;
    localparam logic [6:0] V_FREEZE = 7'b0000_001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PC_LE, IFID_LE, IDEX_LE, EXMEM_LE;
    logic        control_select, IFID_flush, MEMWB_bubble, mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles;

    int compared = 0;
    int mismatched = 0;
    int exp_stall = 0;

    pipeline_stall_controller #(
        .LOAD_STALL_CYCLES(3),
        .MEM_TIMEOUT      (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_hazard   (load_hazard),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .PC_LE         (PC_LE),
        .IFID_LE       (IFID_LE),
        .IDEX_LE       (IDEX_LE),
        .EXMEM_LE      (EXMEM_LE),
        .control_select(control_select),
        .IFID_flush    (IFID_flush),
        .MEMWB_bubble  (MEMWB_bubble),
        .mem_timeout   (mem_timeout),
        .ctrl_state    (ctrl_state),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [6:0] ev, input logic [1:0] es);
        chk({tag, ".ctl"}, {25'd0, PC_LE, IFID_LE, IDEX_LE, EXMEM_LE,
                            control_select, IFID_flush, MEMWB_bubble}, {25'd0, ev});
        chk({tag, ".st"}, {30'd0, ctrl_state}, {30'd0, es});
    endtask

    task automatic chk_stats(input string tag);
`ifdef PIPE_STALL_STATS_EN
        chk(tag, stall_cycles, exp_stall);
`else
        chk(tag, stall_cycles, 32'd0);
`endif
    endtask

    // One clock cycle: drive inputs after the edge, check mid-cycle, advance past the next edge.
    task automatic cyc(input string tag, input logic lh, input logic bt, input logic mr,
                       input logic mrdy, input logic [6:0] ev, input logic [1:0] es);
        load_hazard  = lh;
        branch_taken = bt;
        mem_req      = mr;
        mem_ready    = mrdy;
        @(negedge clk);
        chk_outs(tag, ev, es);
        if (!ev[6] && es != 2'd0) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", V_RESET, 2'd0);
        chk("reset.to", {31'd0, mem_timeout}, 32'd0);
        chk_stats("reset.stats");
        reset = 1'b0;
        cyc("hold", 0, 0, 0, 0, V_RESET, 2'd0);
        cyc("run0", 0, 0, 0, 0, V_RUN, 2'd1);

        // load-use stall of three cycles
        cyc("ld1", 1, 0, 0, 0, V_STALL, 2'd1);
        cyc("ld2", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("ld3", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("ld_end", 0, 0, 0, 0, V_RUN, 2'd1);
        chk_stats("ld.stats");

        // load hazard wins over branch; branch during stall ignored; later branch flushes once
        cyc("lb1", 1, 1, 0, 0, V_STALL, 2'd1);
        cyc("lb2", 0, 1, 0, 0, V_STALL, 2'd2);
        cyc("lb3", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("br", 0, 1, 0, 0, V_FLUSH, 2'd1);
        cyc("br_end", 0, 0, 1, 1, V_RUN, 2'd1);

        // four frozen cycles then release
        cyc("mw1", 0, 0, 1, 0, V_FREEZE, 2'd1);
        cyc("mw2", 0, 0, 1, 0, V_FREEZE, 2'd3);
        cyc("mw3", 0, 0, 1, 0, V_FREEZE, 2'd3);
        cyc("mw4", 0, 0, 1, 0, V_FREEZE, 2'd3);
        cyc("mw_rel", 1, 1, 1, 1, V_RUN, 2'd3);
        cyc("mw_end", 0, 0, 0, 0, V_RUN, 2'd1);
        chk_stats("mw.stats");

        // freeze has priority over load hazard and branch
        cyc("pri1", 1, 1, 1, 0, V_FREEZE, 2'd1);
        cyc("pri_rel", 0, 0, 1, 1, V_RUN, 2'd3);
        cyc("pri_end", 0, 0, 0, 0, V_RUN, 2'd1);

        // freeze during second load-stall cycle resumes the stall: five PC_LE=0 cycles
        cyc("ls1", 1, 0, 0, 0, V_STALL, 2'd1);
        cyc("ls_fz1", 0, 0, 1, 0, V_FREEZE, 2'd2);
        cyc("ls_fz2", 0, 0, 1, 0, V_FREEZE, 2'd3);
        cyc("ls_rel", 0, 0, 1, 1, V_RUN, 2'd3);
        cyc("ls2", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("ls3", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("ls_end", 0, 0, 0, 0, V_RUN, 2'd1);
        chk_stats("ls.stats");

        // watchdog: entry freeze plus six MEM_WAIT frozen cycles, forced release on the seventh
        cyc("to_fz", 0, 0, 1, 0, V_FREEZE, 2'd1);
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("to_w%0d", i), 0, 0, 1, 0, V_FREEZE, 2'd3);
        end
        chk("to.pre", {31'd0, mem_timeout}, 32'd0);
        cyc("to_rel", 0, 0, 1, 0, V_RUN, 2'd3);
        chk("to.set", {31'd0, mem_timeout}, 32'd1);
        cyc("to_run", 0, 0, 0, 0, V_RUN, 2'd1);
        cyc("to_ld", 1, 0, 0, 0, V_STALL, 2'd1);
        cyc("to_ld2", 0, 0, 0, 0, V_STALL, 2'd2);
        chk("to.sticky", {31'd0, mem_timeout}, 32'd1);
        chk_stats("to.stats");

        // reset mid-MEM_WAIT aborts immediately
        cyc("rs_ld3", 0, 0, 0, 0, V_STALL, 2'd2);
        cyc("rs_fz", 0, 0, 1, 0, V_FREEZE, 2'd1);
        cyc("rs_w", 0, 0, 1, 0, V_FREEZE, 2'd3);
        reset = 1'b1;
        exp_stall = 0;
        #1;
        chk_outs("rs_async", V_RESET, 2'd0);
        chk("rs.to", {31'd0, mem_timeout}, 32'd0);
        chk_stats("rs.stats");
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk_outs("rs_hold", V_RESET, 2'd0);
        @(posedge clk);
        #1;
        cyc("rs_run", 0, 0, 0, 0, V_RUN, 2'd1);
        chk("rs.to2", {31'd0, mem_timeout}, 32'd0);
        chk_stats("rs.stats2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
